// File: rtl/swipt_rx_sequencer.sv
// swipt_rx_sequencer: sequences the SWIPT downlink frame decoder.
// The sequencer waits for stable SWIPT power and then arms the decoder.
// It opens timed listen windows, captures each decoded byte and buffers
// it in a small FIFO with a valid/ready handshake. It retries after a
// window timeout and latches a fault after repeated timeouts.
// Optional build macro SWIPT_SUM_CHECK_EN: when it is defined, each captured
// byte is checked against the decoder bit-sum before it is pushed.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | no power; decoder disarmed, retry count cleared
// SETTLE  | swipt_alive must hold for SETTLE_CYCLES before arming
// ARM     | one-cycle arm pulse with rx_enable low
// LISTEN  | listen window open; waits for a dec_ready rising edge
// CAPTURE | validate the captured byte and push it or drop it
// GAP     | rx_enable low for GAP_CYCLES to clear the decoder
// FAULT   | RETRY_MAX consecutive timeouts; waits for power loss
module swipt_rx_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 100000,
  parameter int unsigned WINDOW_CYCLES = 20000000,
  parameter int unsigned GAP_CYCLES    = 4,
  parameter int unsigned RETRY_MAX     = 3,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned SUM_OFFSET    = 5,
  parameter int unsigned CNT_W         = 25
) (
  input  logic                          clk_i,
  input  logic                          nrst_i,
  input  logic                          swipt_alive_i,
  input  logic                          dec_ready_i,
  input  logic [7:0]                    dec_data_i,
  input  logic [7:0]                    dec_sum_i,
  output logic                          data_start_o,
  output logic                          rx_enable_o,
  output logic [7:0]                    byte_out_o,
  output logic                          byte_valid_o,
  input  logic                          byte_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic [7:0]                    err_timeout_o,
  output logic [7:0]                    err_drop_o,
  output logic                          fault_o,
  output logic [2:0]                    state_dbg_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned RW = $clog2(RETRY_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WINDOW_LOAD = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [RW-1:0]    RETRY_LAST  = RW'(RETRY_MAX);
  localparam logic [AW:0]      FULL_LVL    = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_ARM     = 3'd2,
    S_LISTEN  = 3'd3,
    S_CAPTURE = 3'd4,
    S_GAP     = 3'd5,
    S_FAULT   = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic             prev_q, prev_d;
  logic [7:0]       cap_data_q;
  logic             cap_en;
  logic             byte_ok;
  logic             rise;
  logic             push, pop, full;
  logic             to_inc, drop_inc;
  logic [7:0]       err_to_q, err_drop_q;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic [7:0]       last_q;

`ifdef SWIPT_SUM_CHECK_EN
  logic [7:0] cap_sum_q;

  function automatic logic [7:0] popcnt8(input logic [7:0] v);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {7'd0, v[i]};
    return n;
  endfunction

  assign byte_ok = (cap_sum_q == popcnt8(cap_data_q) + 8'(SUM_OFFSET));
`else
  logic unused_sum;
  assign unused_sum = ^dec_sum_i;
  assign byte_ok    = 1'b1;
`endif

  assign rise         = dec_ready_i & ~prev_q;
  assign byte_valid_o = (count_q != '0);
  assign pop          = byte_valid_o & byte_ready_i;
  assign full         = (count_q == FULL_LVL);
  assign byte_out_o   = byte_valid_o ? mem_q[rd_ptr_q] : last_q;
  assign fifo_level_o = count_q;
  assign err_timeout_o = err_to_q;
  assign err_drop_o   = err_drop_q;
  assign state_dbg_o  = state_q;

  // State, shared counter, retry count and dec_ready edge-detector registers
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      retry_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      prev_q  <= prev_d;
    end
  end

  // Next-state, counter reloads, decoder controls and event strobes
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    retry_d      = retry_q;
    prev_d       = (state_q == S_GAP) ? 1'b0 : dec_ready_i;
    data_start_o = 1'b0;
    rx_enable_o  = 1'b0;
    fault_o      = 1'b0;
    cap_en       = 1'b0;
    push         = 1'b0;
    to_inc       = 1'b0;
    drop_inc     = 1'b0;
    case (state_q)
      S_IDLE: begin
        retry_d = '0;
        if (swipt_alive_i) begin
          state_d = S_SETTLE;
          cnt_d   = SETTLE_LOAD;
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) state_d = S_ARM;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_ARM: begin
        data_start_o = 1'b1;
        state_d      = S_LISTEN;
        cnt_d        = WINDOW_LOAD;
      end
      S_LISTEN: begin
        data_start_o = 1'b1;
        rx_enable_o  = 1'b1;
        if (rise) begin
          // An edge in the expiry cycle still counts as a capture.
          cap_en  = 1'b1;
          state_d = S_CAPTURE;
        end else if (cnt_q == '0) begin
          to_inc  = 1'b1;
          retry_d = retry_q + RW'(1);
          if (retry_d == RETRY_LAST) begin
            state_d = S_FAULT;
          end else begin
            state_d = S_GAP;
            cnt_d   = GAP_LOAD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_CAPTURE: begin
        data_start_o = 1'b1;
        rx_enable_o  = 1'b1;
        retry_d      = '0;
        // A full FIFO still accepts the byte when the head pops this cycle.
        if (byte_ok && (!full || pop)) push     = 1'b1;
        else                           drop_inc = 1'b1;
        state_d = S_GAP;
        cnt_d   = GAP_LOAD;
      end
      S_GAP: begin
        data_start_o = 1'b1;
        if (cnt_q == '0) begin
          state_d = S_LISTEN;
          cnt_d   = WINDOW_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FAULT: begin
        fault_o = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // Power loss overrides every sequencing decision; FIFO and error counts survive.
    if (!swipt_alive_i && state_q != S_IDLE) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      retry_d = '0;
    end
  end

  // Capture decoder byte (and bit-sum) on the qualifying dec_ready edge
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      cap_data_q <= '0;
`ifdef SWIPT_SUM_CHECK_EN
      cap_sum_q  <= '0;
`endif
    end else if (cap_en) begin
      cap_data_q <= dec_data_i;
`ifdef SWIPT_SUM_CHECK_EN
      cap_sum_q  <= dec_sum_i;
`endif
    end
  end

  // FIFO occupancy next value; push plus pop leaves the level unchanged
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage and pointers; last_q keeps byte_out stable once empty
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= cap_data_q;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        last_q   <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

  // Saturating timeout and drop counters, cleared only by reset
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      err_to_q   <= '0;
      err_drop_q <= '0;
    end else begin
      if (to_inc && err_to_q != 8'hFF)     err_to_q   <= err_to_q + 1'b1;
      if (drop_inc && err_drop_q != 8'hFF) err_drop_q <= err_drop_q + 1'b1;
    end
  end

endmodule
